// File: rtl/enc_pkg.sv
// Shared constants and helpers for the registered 4-to-2 priority encoder.
package enc_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned CODE_W  = 2;

  // Expand a 2-bit code into its 4-bit one-hot request mask.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [CODE_W-1:0] code);
    logic [NUM_REQ-1:0] mask;
    mask = '0;
    mask[code] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/enc_pick4.sv
// Combinational 4-way picker: searches cand downward from index start, wrapping
// from 0 back to 3, and reports the first set index.
module enc_pick4
  import enc_pkg::*;
(
  input  logic [NUM_REQ-1:0] cand,
  input  logic [CODE_W-1:0]  start,
  output logic [CODE_W-1:0]  sel,
  output logic               any
);

  // Descending search with wrap; the first hit wins.
  always_comb begin
    logic [CODE_W-1:0] idx;
    sel = '0;
    any = 1'b0;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = start - i[CODE_W-1:0];
      if (!any && cand[idx]) begin
        sel = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder_4_to_2_seq.sv
// Registered 4-to-2 priority encoder with request capture and a valid/ready
// output. Requests are level-sampled into a pending set and granted one per
// transfer. Define ENCODER_RR_EN for round-robin priority; otherwise index 3
// always wins.
module encoder_4_to_2_seq
  import enc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               ready,
  output logic [CODE_W-1:0]  code,
  output logic               valid,
  output logic [NUM_REQ-1:0] pending,
  output logic               overrun
);

  logic [NUM_REQ-1:0] pend_q;
  logic [CODE_W-1:0]  code_q;
  logic               valid_q;
  logic               overrun_q;

  logic [NUM_REQ-1:0] cand;
  logic [CODE_W-1:0]  start;
  logic [CODE_W-1:0]  sel;
  logic               any;
  logic               free;
  logic               load;
  logic [NUM_REQ-1:0] pend_d;

`ifdef ENCODER_RR_EN
  logic [CODE_W-1:0] ptr_q;

  // Round-robin pointer: next search begins just below the last grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 2'b11;
    end else if (load) begin
      ptr_q <= sel - 2'd1;
    end
  end

  assign start = ptr_q;
`else
  assign start = 2'b11;
`endif

  enc_pick4 u_pick (
    .cand  (cand),
    .start (start),
    .sel   (sel),
    .any   (any)
  );

  // Candidate set, load decision and next pending set; a same-cycle request
  // for the granted index is absorbed by that grant.
  always_comb begin
    cand   = pend_q | req;
    free   = !valid_q || ready;
    load   = free && any;
    pend_d = cand & ~(load ? onehot(sel) : '0);
  end

  // Output, pending and overrun registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q    <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      overrun_q <= |(req & pend_q);
      if (load) begin
        code_q <= sel;
      end
      if (free) begin
        valid_q <= any;
      end
    end
  end

  assign code    = code_q;
  assign valid   = valid_q;
  assign pending = pend_q;
  assign overrun = overrun_q;

endmodule
